gpio_irq_ctrl: RTL and testbench



---
 rtl/gpio_pkg.sv | 21 ++
 rtl/gpio_irq_ctrl_if.sv | 11 +
 rtl/gpio_rr_pick.sv | 27 ++
 rtl/gpio_irq_ctrl.sv | 112 +++++++++++
 tb/tb_gpio_irq_ctrl.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/gpio_pkg.sv
// Shared gpio definitions: the interrupt FSM state encoding and the conf_1 field layout.
// The conf_1 offsets must stay in step with the gpio register map.
package gpio_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        ACK   = 2'd2,
        REARM = 2'd3
    } gpio_irq_state_t;

    // conf_1 holds four PORT_NUM-wide fields. Each offset is a multiple of PORT_NUM.
    localparam int CONF1_ESEL_MUL = 0;
    localparam int CONF1_EN_MUL   = 2;
    localparam int CONF1_STAT_MUL = 3;

    function automatic int conf1_stat_off(input int port_num);
        return CONF1_STAT_MUL * port_num;
    endfunction

endpackage

// File: rtl/gpio_irq_ctrl_if.sv
// Host-side interrupt offer channel: a port ID travels under a valid/ready handshake.
interface gpio_irq_ctrl_if #(
    parameter int ID_W = 3
) ();
    logic            irq_valid;
    logic            irq_ready;
    logic [ID_W-1:0] irq_id;

    modport master (output irq_valid, output irq_id, input irq_ready);
    modport slave  (input irq_valid, input irq_id, output irq_ready);
endinterface

// File: rtl/gpio_rr_pick.sv
// Combinational round-robin picker. It returns the first set bit of pending,
// scanning upward from last+1 and wrapping modulo PORT_NUM.
module gpio_rr_pick #(
    parameter int PORT_NUM = 8,
    parameter int ID_W     = $clog2(PORT_NUM)
) (
    input  logic [PORT_NUM-1:0] pending,
    input  logic [ID_W-1:0]     last,
    output logic                found,
    output logic [ID_W-1:0]     sel_id
);
    logic [ID_W-1:0] cand;

    // Scan from the farthest offset down to the nearest, so the nearest match wins.
    always_comb begin
        found  = 1'b0;
        sel_id = '0;
        cand   = '0;
        for (int i = PORT_NUM; i >= 1; i--) begin
            cand = ID_W'((int'(last) + i) % PORT_NUM);
            if (pending[cand]) begin
                found  = 1'b1;
                sel_id = cand;
            end
        end
    end
endmodule

// File: rtl/gpio_irq_ctrl.sv
// gpio interrupt scheduler: round-robin selection, host offer, and a one-cycle ack to the port.
// The optional re-arm write of conf_1 is enabled with GPIO_IRQ_REARM_EN.
module gpio_irq_ctrl
    import gpio_pkg::*;
#(
    parameter int PORT_NUM = 8,
    parameter int ID_W     = $clog2(PORT_NUM),
    parameter int CNT_W    = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [PORT_NUM-1:0]   ir_valid,
    output logic [PORT_NUM-1:0]   ir_ready,
    input  logic [PORT_NUM-1:0]   irq_mask,
    gpio_irq_ctrl_if.master       irq,
    output logic [CNT_W-1:0]      irq_count,
    output logic                  busy
`ifdef GPIO_IRQ_REARM_EN
    ,
    output logic                  conf_1_valid,
    input  logic                  conf_1_ready,
    input  logic [4*PORT_NUM-1:0] conf_1_shadow,
    output logic [4*PORT_NUM-1:0] conf_1
`endif
);
    gpio_irq_state_t      state;
    logic [ID_W-1:0]      last;
    logic [PORT_NUM-1:0]  pending;
    logic                 found;
    logic [ID_W-1:0]      sel_id;
    logic [PORT_NUM-1:0]  ack_oh;

    assign pending = ir_valid & ~irq_mask;

    gpio_rr_pick #(.PORT_NUM(PORT_NUM), .ID_W(ID_W)) u_pick (
        .pending (pending),
        .last    (last),
        .found   (found),
        .sel_id  (sel_id)
    );

    always_comb begin
        ack_oh            = '0;
        ack_oh[irq.irq_id] = 1'b1;
    end

`ifdef GPIO_IRQ_REARM_EN
    logic [4*PORT_NUM-1:0] stat_clr;
    assign stat_clr = {{(4*PORT_NUM-1){1'b0}}, 1'b1} << (conf1_stat_off(PORT_NUM) + int'(irq.irq_id));
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            last          <= ID_W'(PORT_NUM - 1);
            ir_ready      <= '0;
            irq.irq_valid <= 1'b0;
            irq.irq_id    <= '0;
            irq_count     <= '0;
            busy          <= 1'b0;
`ifdef GPIO_IRQ_REARM_EN
            conf_1_valid  <= 1'b0;
            conf_1        <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    ir_ready <= '0;
                    if (found) begin
                        irq.irq_id    <= sel_id;
                        irq.irq_valid <= 1'b1;
                        busy          <= 1'b1;
                        state         <= OFFER;
                    end
                end
                // Once offered, the grant is committed: mask and ir_valid are ignored here.
                OFFER: begin
                    if (irq.irq_ready) begin
                        irq.irq_valid <= 1'b0;
                        ir_ready      <= ack_oh;
                        last          <= irq.irq_id;
                        state         <= ACK;
                    end
                end
                ACK: begin
                    ir_ready <= '0;
                    if (~&irq_count) irq_count <= irq_count + CNT_W'(1);
`ifdef GPIO_IRQ_REARM_EN
                    conf_1       <= conf_1_shadow & ~stat_clr;
                    conf_1_valid <= 1'b1;
                    state        <= REARM;
`else
                    busy         <= 1'b0;
                    state        <= IDLE;
`endif
                end
                default: begin
`ifdef GPIO_IRQ_REARM_EN
                    if (conf_1_ready) begin
                        conf_1_valid <= 1'b0;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end
`else
                    busy  <= 1'b0;
                    state <= IDLE;
`endif
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Directed bench for gpio_irq_ctrl. It covers reset, offer/ack, round-robin, masking,
// reset mid-offer, count saturation and, with GPIO_IRQ_REARM_EN, the re-arm write.
module tb_gpio_irq_ctrl;
    localparam int PORT_NUM = 8;
    localparam int ID_W     = 3;
    localparam int CNT_W    = 4;

    logic                  clock = 1'b0;
    logic                  reset = 1'b1;
    logic [PORT_NUM-1:0]   ir_valid = '0;
    logic [PORT_NUM-1:0]   ir_ready;
    logic [PORT_NUM-1:0]   irq_mask = '0;
    logic [CNT_W-1:0]      irq_count;
    logic                  busy;
`ifdef GPIO_IRQ_REARM_EN
    logic                  conf_1_valid;
    logic                  conf_1_ready = 1'b1;
    logic [4*PORT_NUM-1:0] conf_1_shadow = '0;
    logic [4*PORT_NUM-1:0] conf_1;
`endif

    int n_cmp = 0;
    int n_err = 0;

    gpio_irq_ctrl_if #(.ID_W(ID_W)) irq_if ();

    gpio_irq_ctrl #(.PORT_NUM(PORT_NUM), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
        .clock         (clock),
        .reset         (reset),
        .ir_valid      (ir_valid),
        .ir_ready      (ir_ready),
        .irq_mask      (irq_mask),
        .irq           (irq_if.master),
        .irq_count     (irq_count),
        .busy          (busy)
`ifdef GPIO_IRQ_REARM_EN
        ,
        .conf_1_valid  (conf_1_valid),
        .conf_1_ready  (conf_1_ready),
        .conf_1_shadow (conf_1_shadow),
        .conf_1        (conf_1)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Run one full grant with the host ready. While ACK is high, gpio swaps in new_valid.
    task automatic grant(input logic [ID_W-1:0] exp_id, input logic [PORT_NUM-1:0] new_valid);
        irq_if.irq_ready = 1'b1;
        tick();
        chk("offer_valid", 64'(irq_if.irq_valid), 64'd1);
        chk("offer_id", 64'(irq_if.irq_id), 64'(exp_id));
        tick();
        chk("ack_onehot", 64'(ir_ready), 64'(8'h01 << exp_id));
        chk("ack_drop_valid", 64'(irq_if.irq_valid), 64'd0);
        ir_valid = new_valid;
        tick();
`ifdef GPIO_IRQ_REARM_EN
        chk("rearm_valid", 64'(conf_1_valid), 64'd1);
        tick();
`endif
        chk("ack_one_cycle", 64'(ir_ready), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        irq_if.irq_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_irq_valid", 64'(irq_if.irq_valid), 64'd0);
        chk("rst_ir_ready", 64'(ir_ready), 64'd0);
        chk("rst_irq_id", 64'(irq_if.irq_id), 64'd0);
        chk("rst_count", 64'(irq_count), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);

        // Test 1: the offer is held while the host stalls.
        ir_valid = 8'h04;
        tick();
        chk("t1_valid", 64'(irq_if.irq_valid), 64'd1);
        chk("t1_id", 64'(irq_if.irq_id), 64'd2);
        chk("t1_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 5; i++) tick();
        chk("t1_hold_valid", 64'(irq_if.irq_valid), 64'd1);
        chk("t1_hold_id", 64'(irq_if.irq_id), 64'd2);
        chk("t1_no_ack", 64'(ir_ready), 64'd0);
        irq_if.irq_ready = 1'b1;
        tick();
        chk("t1_ack", 64'(ir_ready), 64'h04);
        ir_valid = 8'h00;
        irq_if.irq_ready = 1'b0;
        tick();
`ifdef GPIO_IRQ_REARM_EN
        tick();
`endif
        chk("t1_ack_clear", 64'(ir_ready), 64'd0);
        chk("t1_count", 64'(irq_count), 64'd1);
        chk("t1_idle_valid", 64'(irq_if.irq_valid), 64'd0);

        // Test 2: two ports held active must alternate from a fresh reset.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ir_valid = 8'h81;
        grant(3'd0, 8'h81);
        grant(3'd7, 8'h81);
        grant(3'd0, 8'h81);
        grant(3'd7, 8'h40);
        chk("t2_count", 64'(irq_count), 64'd4);

        // Test 3: wrap from last=6 goes to 0, then back to 6.
        grant(3'd6, 8'h41);
        grant(3'd0, 8'h40);
        grant(3'd6, 8'h00);
        chk("t3_count", 64'(irq_count), 64'd7);

        // Test 4: a masked port is never offered, and masking mid-offer does not retract it.
        irq_if.irq_ready = 1'b0;
        irq_mask = 8'h04;
        ir_valid = 8'h04;
        tick();
        tick();
        chk("t4_masked_valid", 64'(irq_if.irq_valid), 64'd0);
        chk("t4_masked_busy", 64'(busy), 64'd0);
        irq_mask = 8'h00;
        tick();
        chk("t4_unmask_valid", 64'(irq_if.irq_valid), 64'd1);
        chk("t4_unmask_id", 64'(irq_if.irq_id), 64'd2);
        irq_mask = 8'h04;
        tick();
        chk("t4_committed", 64'(irq_if.irq_valid), 64'd1);
        irq_if.irq_ready = 1'b1;
        tick();
        chk("t4_ack", 64'(ir_ready), 64'h04);
        ir_valid = 8'h00;
        irq_mask = 8'h00;
        tick();
`ifdef GPIO_IRQ_REARM_EN
        tick();
`endif
        chk("t4_count", 64'(irq_count), 64'd8);

        // Test 5: reset drops an in-flight offer, and the held request is offered again.
        irq_if.irq_ready = 1'b0;
        ir_valid = 8'h08;
        tick();
        chk("t5_offer", 64'(irq_if.irq_valid), 64'd1);
        reset = 1'b1;
        tick();
        chk("t5_rst_valid", 64'(irq_if.irq_valid), 64'd0);
        chk("t5_rst_ack", 64'(ir_ready), 64'd0);
        chk("t5_rst_count", 64'(irq_count), 64'd0);
        chk("t5_rst_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        tick();
        chk("t5_reoffer_valid", 64'(irq_if.irq_valid), 64'd1);
        chk("t5_reoffer_id", 64'(irq_if.irq_id), 64'd3);

`ifdef GPIO_IRQ_REARM_EN
        // Test 6: the re-arm write clears the status bit of port 3 and waits for conf_1_ready.
        conf_1_ready = 1'b0;
        conf_1_shadow = 32'hFF00_0000;
        irq_if.irq_ready = 1'b1;
        tick();
        chk("t6_ack", 64'(ir_ready), 64'h08);
        ir_valid = 8'h00;
        irq_if.irq_ready = 1'b0;
        tick();
        chk("t6_conf_valid", 64'(conf_1_valid), 64'd1);
        chk("t6_conf_word", 64'(conf_1), 64'hF700_0000);
        tick();
        tick();
        chk("t6_conf_hold", 64'(conf_1_valid), 64'd1);
        chk("t6_conf_hold_word", 64'(conf_1), 64'hF700_0000);
        chk("t6_busy_rearm", 64'(busy), 64'd1);
        conf_1_ready = 1'b1;
        tick();
        chk("t6_conf_done", 64'(conf_1_valid), 64'd0);
        chk("t6_busy_done", 64'(busy), 64'd0);
        conf_1_shadow = '0;
`else
        irq_if.irq_ready = 1'b1;
        tick();
        chk("t5_ack", 64'(ir_ready), 64'h08);
        ir_valid = 8'h00;
        tick();
`endif
        chk("t5_count", 64'(irq_count), 64'd1);

        // Saturation: the 4-bit counter reaches 15 and then stays there.
        ir_valid = 8'h01;
        for (int i = 0; i < 14; i++) grant(3'd0, 8'h01);
        chk("sat_reach", 64'(irq_count), 64'd15);
        grant(3'd0, 8'h01);
        grant(3'd0, 8'h00);
        chk("sat_hold", 64'(irq_count), 64'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
